// File: rtl/dm_responder_pkg.sv
// Shared types for the data-memory responder:
// access size codes, FSM states and the latched request bundle.
package dm_responder_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSV  = 2'b11;

  typedef enum logic [1:0] {
    DM_IDLE = 2'd0,
    DM_WAIT = 2'd1,
    DM_RESP = 2'd2
  } dm_state_e;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic        sgn;
  } dm_req_t;

endpackage

// File: rtl/dm_lane_ext.sv
// Byte-lane steering: store merge into the old word and
// load extract with sign/zero extension (little-endian).
module dm_lane_ext
  import dm_responder_pkg::*;
(
  input  logic [1:0]  lo,
  input  logic [1:0]  size,
  input  logic        sgn,
  input  logic [31:0] wdata,
  input  logic [31:0] oldw,
  input  logic [31:0] rword,
  output logic [31:0] merged,
  output logic [31:0] rdata
);

  logic [4:0]  bsh;
  logic [4:0]  hsh;
  logic [31:0] bmask;
  logic [31:0] hmask;
  logic [7:0]  bval;
  logic [15:0] hval;

  always_comb begin
    bsh    = {lo, 3'b000};
    hsh    = {lo[1], 4'b0000};
    bmask  = 32'h0000_00ff << bsh;
    hmask  = 32'h0000_ffff << hsh;
    bval   = rword[bsh +: 8];
    hval   = rword[hsh +: 16];
    merged = oldw;
    rdata  = '0;
    unique case (1'b1)
      (size == SZ_BYTE): begin
        merged = (oldw & ~bmask)
               | ({24'b0, wdata[7:0]} << bsh);
        rdata  = {{24{sgn & bval[7]}}, bval};
      end
      (size == SZ_HALF): begin
        merged = (oldw & ~hmask)
               | ({16'b0, wdata[15:0]} << hsh);
        rdata  = {{16{sgn & hval[15]}}, hval};
      end
      (size == SZ_WORD): begin
        merged = wdata;
        rdata  = rword;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dm_responder.sv
// MEM-stage load/store target: one request at a time,
// programmable wait states, lane merge/extract, error flagging.
module dm_responder
  import dm_responder_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [1:0]  mem_size,
  input  logic        mem_signed,
  output logic        mem_busy,
  output logic        mem_ack,
  output logic [31:0] mem_rdata,
  output logic        mem_err
);

  localparam int          AW       = $clog2(DEPTH_WORDS);
  localparam logic [29:0] BASEW    = BASE_ADDR[31:2];
  localparam logic [29:0] NWORDS   = 30'(DEPTH_WORDS);
  localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

  dm_state_e   state_q;
  dm_state_e   state_d;
  logic [3:0]  cnt_q;
  logic [3:0]  cnt_d;
  dm_req_t     req_q;

  logic [31:0] ram [DEPTH_WORDS];
  logic [29:0] woff;
  logic [AW-1:0] widx;
  logic        bad;
  logic [31:0] rword;
  logic [31:0] merged;
  logic [31:0] ldval;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= DM_IDLE;
      cnt_q   <= '0;
      req_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == DM_IDLE && mem_req)
        req_q <= '{we:    mem_we,
                   addr:  mem_addr,
                   wdata: mem_wdata,
                   size:  mem_size,
                   sgn:   mem_signed};
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      DM_IDLE: begin
        if (mem_req) begin
          if (LATENCY == 0) begin
            state_d = DM_RESP;
          end else begin
            state_d = DM_WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      DM_WAIT: begin
        if (cnt_q == '0)
          state_d = DM_RESP;
        else
          cnt_d = cnt_q - 4'd1;
      end
      DM_RESP: state_d = DM_IDLE;
      default: state_d = DM_IDLE;
    endcase
  end

  // Subtracting at word granularity also flags addresses below base
  assign woff = req_q.addr[31:2] - BASEW;
  assign widx = woff[AW-1:0];

  always_comb begin
    bad = 1'b0;
    unique case (1'b1)
      (req_q.size == SZ_HALF): bad = req_q.addr[0];
      (req_q.size == SZ_WORD): bad = |req_q.addr[1:0];
      (req_q.size == SZ_RSV):  bad = 1'b1;
      default:                 bad = 1'b0;
    endcase
    if (woff >= NWORDS)
      bad = 1'b1;
  end

  assign rword = ram[widx];

  dm_lane_ext u_lane (
    .lo     (req_q.addr[1:0]),
    .size   (req_q.size),
    .sgn    (req_q.sgn),
    .wdata  (req_q.wdata),
    .oldw   (rword),
    .rword  (rword),
    .merged (merged),
    .rdata  (ldval)
  );

  // Write lands on the edge closing RESP; async reset clears RESP first
  always_ff @(posedge clk) begin
    if (state_q == DM_RESP && req_q.we && !bad)
      ram[widx] <= merged;
  end

  assign mem_busy  = (state_q != DM_IDLE);
  assign mem_ack   = (state_q == DM_RESP);
  assign mem_err   = mem_ack & bad;
  assign mem_rdata = (mem_ack && !bad && !req_q.we)
                   ? ldval : 32'h0;

endmodule

// File: tb/tb_dm_responder.sv
// Directed bench for dm_responder: word/byte/half traffic,
// error cases, back-to-back request holding and mid-wait reset.
module tb_dm_responder;
  import dm_responder_pkg::*;

  localparam int LAT = 2;
  localparam int DEP = 1024;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        mem_req = 1'b0;
  logic        mem_we = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic [1:0]  mem_size = '0;
  logic        mem_signed = 1'b0;
  logic        mem_busy;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        mem_err;

  int n_chk = 0;
  int n_fail = 0;

  dm_responder #(
    .DEPTH_WORDS (DEP),
    .BASE_ADDR   (32'h0),
    .LATENCY     (LAT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_size   (mem_size),
    .mem_signed (mem_signed),
    .mem_busy   (mem_busy),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .mem_err    (mem_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Entered #1 after a rising edge with the DUT idle
  task automatic do_req(input string tag,
                        input logic we,
                        input logic [31:0] a,
                        input logic [31:0] wd,
                        input logic [1:0] sz,
                        input logic sg,
                        output logic [31:0] rd,
                        output logic er);
    int lat;
    int quiet;
    mem_req    = 1'b1;
    mem_we     = we;
    mem_addr   = a;
    mem_wdata  = wd;
    mem_size   = sz;
    mem_signed = sg;
    @(posedge clk); #1;
    mem_req = 1'b0;
    lat   = 1;
    quiet = 0;
    while (!mem_ack && lat < 20) begin
      if (mem_rdata != 0 || mem_err) quiet++;
      @(posedge clk); #1;
      lat++;
    end
    rd = mem_rdata;
    er = mem_err;
    chk({tag, "_lat"}, lat, LAT + 1);
    chk({tag, "_quiet"}, quiet, 0);
    chk({tag, "_busy"}, {31'b0, mem_busy}, 1);
    @(posedge clk); #1;
    chk({tag, "_ackpulse"}, {31'b0, mem_ack}, 0);
  endtask

  task automatic st(input string tag, input logic [31:0] a,
                    input logic [31:0] wd, input logic [1:0] sz);
    logic [31:0] rd;
    logic er;
    do_req(tag, 1'b1, a, wd, sz, 1'b0, rd, er);
    chk({tag, "_err"}, {31'b0, er}, 0);
  endtask

  task automatic ld(input string tag, input logic [31:0] a,
                    input logic [1:0] sz, input logic sg,
                    input logic [31:0] exp);
    logic [31:0] rd;
    logic er;
    do_req(tag, 1'b0, a, 32'h0, sz, sg, rd, er);
    chk({tag, "_rdata"}, rd, exp);
    chk({tag, "_err"}, {31'b0, er}, 0);
  endtask

  task automatic bad(input string tag, input logic we,
                     input logic [31:0] a, input logic [1:0] sz);
    logic [31:0] rd;
    logic er;
    do_req(tag, we, a, 32'hFFFF_FFFF, sz, 1'b1, rd, er);
    chk({tag, "_err"}, {31'b0, er}, 1);
    chk({tag, "_rdata"}, rd, 0);
  endtask

  int rises[$];
  int acks;
  int ack_nobusy;
  int rd_bad;
  int late_acks;
  logic pbusy;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {31'b0, mem_busy}, 0);
    chk("rst_ack", {31'b0, mem_ack}, 0);
    chk("rst_err", {31'b0, mem_err}, 0);
    chk("rst_rdata", mem_rdata, 0);
    reset = 1'b1;
    @(posedge clk); #1;

    st("sw10", 32'h10, 32'h1234_5678, SZ_WORD);
    ld("lw10", 32'h10, SZ_WORD, 1'b0, 32'h1234_5678);

    st("sb13", 32'h13, 32'h5555_55AB, SZ_BYTE);
    ld("lw10b", 32'h10, SZ_WORD, 1'b0, 32'hAB34_5678);
    ld("lb13", 32'h13, SZ_BYTE, 1'b1, 32'hFFFF_FFAB);
    ld("lbu13", 32'h13, SZ_BYTE, 1'b0, 32'h0000_00AB);
    ld("lb10", 32'h10, SZ_BYTE, 1'b1, 32'h0000_0078);
    ld("lbu11", 32'h11, SZ_BYTE, 1'b0, 32'h0000_0056);

    st("sw20", 32'h20, 32'h1122_3344, SZ_WORD);
    st("sh22", 32'h22, 32'hCCCC_8001, SZ_HALF);
    ld("lw20", 32'h20, SZ_WORD, 1'b0, 32'h8001_3344);
    ld("lh22", 32'h22, SZ_HALF, 1'b1, 32'hFFFF_8001);
    ld("lhu22", 32'h22, SZ_HALF, 1'b0, 32'h0000_8001);
    ld("lh20", 32'h20, SZ_HALF, 1'b1, 32'h0000_3344);
    ld("lws20", 32'h20, SZ_WORD, 1'b1, 32'h8001_3344);

    st("sw0", 32'h0, 32'h0000_CAFE, SZ_WORD);
    st("swtop", 32'hFFC, 32'hA5A5_5A5A, SZ_WORD);
    ld("lwtop", 32'hFFC, SZ_WORD, 1'b0, 32'hA5A5_5A5A);

    bad("e_lw11", 1'b0, 32'h11, SZ_WORD);
    bad("e_sh23", 1'b1, 32'h23, SZ_HALF);
    bad("e_sw_oob", 1'b1, 32'h1000, SZ_WORD);
    bad("e_rsv", 1'b1, 32'h10, SZ_RSV);
    bad("e_lh21", 1'b0, 32'h21, SZ_HALF);
    ld("post_e20", 32'h20, SZ_WORD, 1'b0, 32'h8001_3344);
    ld("post_e0", 32'h0, SZ_WORD, 1'b0, 32'h0000_CAFE);
    ld("post_e10", 32'h10, SZ_WORD, 1'b0, 32'hAB34_5678);

    // Request held high: accepts every LAT+2 edges
    mem_req  = 1'b1;
    mem_we   = 1'b0;
    mem_addr = 32'h10;
    mem_size = SZ_WORD;
    pbusy    = 1'b0;
    acks = 0; ack_nobusy = 0; rd_bad = 0;
    for (int i = 1; i <= 17; i++) begin
      @(posedge clk); #1;
      if (mem_busy && !pbusy) rises.push_back(i);
      if (mem_ack) begin
        acks++;
        if (!mem_busy) ack_nobusy++;
        if (mem_rdata != 32'hAB34_5678) rd_bad++;
      end
      pbusy = mem_busy;
    end
    mem_req = 1'b0;
    repeat (LAT + 3) @(posedge clk);
    #1;
    chk("hold_accepts", rises.size(), 5);
    chk("hold_acks", acks, 4);
    chk("hold_ack_busy", ack_nobusy, 0);
    chk("hold_rdata", rd_bad, 0);
    for (int i = 1; i < rises.size(); i++)
      chk("hold_gap", rises[i] - rises[i-1], LAT + 2);

    // Reset while the store is still waiting
    st("sw40", 32'h40, 32'h0BAD_F00D, SZ_WORD);
    mem_req   = 1'b1;
    mem_we    = 1'b1;
    mem_addr  = 32'h40;
    mem_wdata = 32'hDEAD_BEEF;
    mem_size  = SZ_WORD;
    @(posedge clk); #1;
    mem_req = 1'b0;
    chk("rw_busy", {31'b0, mem_busy}, 1);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    chk("rw_busy0", {31'b0, mem_busy}, 0);
    chk("rw_ack0", {31'b0, mem_ack}, 0);
    chk("rw_rdata0", mem_rdata, 0);
    chk("rw_err0", {31'b0, mem_err}, 0);
    late_acks = 0;
    repeat (2) begin
      @(posedge clk); #1;
      if (mem_ack) late_acks++;
    end
    reset = 1'b1;
    repeat (6) begin
      @(posedge clk); #1;
      if (mem_ack || mem_busy) late_acks++;
    end
    chk("rw_noack", late_acks, 0);
    ld("rw_lw40", 32'h40, SZ_WORD, 1'b0, 32'h0BAD_F00D);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
